// File: rtl/vend_pkg.sv
// Shared types, catalogue constants and slot/price helpers for the vending
// transaction engine.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRICE,
    ST_DISPENSE,
    ST_RESULT
  } state_e;

  localparam int unsigned DEF_ROWS  = 4;
  localparam int unsigned DEF_COLS  = 4;
  localparam int unsigned NUM_SLOTS = 16;

  localparam logic [11:0] PRICE_BASE = 12'd50;
  localparam logic [11:0] PRICE_STEP = 12'd25;
  localparam logic [11:0] USD_MAX    = 12'd999;

  function automatic logic [11:0] price_of(input logic [3:0] slot);
    return PRICE_BASE + PRICE_STEP * 12'(slot);
  endfunction

  // Row digits start at 1, so row 1 col 0 is slot 0.
  function automatic logic [3:0] slot_of(input logic [7:0] code,
                                         input logic [3:0] cols = 4'(DEF_COLS));
    return (code[7:4] - 4'd1) * cols + code[3:0];
  endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-slot stock counters with bulk reload and a single guarded decrement.
module vend_stock_bank
  import vend_pkg::*;
#(
  parameter int unsigned STOCK_INIT = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       restock,
  input  logic       dec,
  input  logic [3:0] dec_slot,
  input  logic [3:0] rd_slot,
  output logic [3:0] rd_count
);

  localparam logic [3:0] INIT = 4'(STOCK_INIT);

  logic [3:0] count_q [NUM_SLOTS];

  // NOTE: this array is reset on purpose -- reload to STOCK_INIT is required
  // behaviour, so it stays in flops rather than an un-resettable RAM.
  always_ff @(posedge clk) begin
    if (reset || restock) begin
      for (int i = 0; i < int'(NUM_SLOTS); i++) count_q[i] <= INIT;
    end else if (dec && (count_q[dec_slot] != 4'd0)) begin
      count_q[dec_slot] <= count_q[dec_slot] - 4'd1;
    end
  end

  assign rd_count = count_q[rd_slot];

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Vending transaction engine: validates the product code, takes payment,
// tracks stock and drives a timed dispense pulse plus display flags.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned ROWS            = DEF_ROWS,
  parameter int unsigned COLS            = DEF_COLS,
  parameter int unsigned STOCK_INIT      = 5,
  parameter int unsigned DISPENSE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  code,
  input  logic        code_strobe,
  input  logic [11:0] usd,
  input  logic        usd_strobe,
  input  logic        cancel,
  input  logic        restock,
  output logic        code_valid,
  output logic        code_invalid,
  output logic        sold_out,
  output logic [11:0] product,
  output logic        usd_enough,
  output logic        usd_invalid,
  output logic [11:0] usd_refund,
  output logic        dispense,
  output logic [3:0]  dispense_slot,
  output logic        busy
);

  localparam logic [7:0] CNT_LOAD = 8'(DISPENSE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [3:0]  slot_q, slot_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        code_valid_q, code_valid_d, code_invalid_q, code_invalid_d;
  logic        sold_out_q, sold_out_d, usd_enough_q, usd_enough_d;
  logic        usd_invalid_q, usd_invalid_d, dispense_q, dispense_d;
  logic [11:0] product_q, product_d, usd_refund_q, usd_refund_d;
  logic [3:0]  dispense_slot_q, dispense_slot_d;

  logic        code_ok, stock_avail, usd_ok, restock_eff, dec, clear_all;
  logic [3:0]  code_slot, rd_count;

  assign code_ok     = (code[7:4] != 4'd0) && (32'(code[7:4]) <= ROWS) &&
                       (32'(code[3:0]) < COLS);
  assign code_slot   = slot_of(code, 4'(COLS));
  assign stock_avail = (rd_count != 4'd0);
  // While in PRICE, product holds the selected slot's price.
  assign usd_ok      = (usd <= USD_MAX) && (usd >= product_q);
  assign restock_eff = restock && ((state_q == ST_IDLE) || (state_q == ST_RESULT));

  vend_stock_bank #(.STOCK_INIT(STOCK_INIT)) u_stock (
    .clk      (clk),
    .reset    (reset),
    .restock  (restock_eff),
    .dec      (dec),
    .dec_slot (slot_q),
    .rd_slot  (code_slot),
    .rd_count (rd_count)
  );

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    slot_d          = slot_q;
    cnt_d           = cnt_q;
    code_valid_d    = code_valid_q;
    code_invalid_d  = code_invalid_q;
    sold_out_d      = sold_out_q;
    product_d       = product_q;
    usd_enough_d    = usd_enough_q;
    usd_invalid_d   = usd_invalid_q;
    usd_refund_d    = usd_refund_q;
    dispense_d      = dispense_q;
    dispense_slot_d = dispense_slot_q;
    dec             = 1'b0;
    clear_all       = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_RESULT: begin
        if (cancel) begin
          clear_all = 1'b1;
          state_d   = ST_IDLE;
        end else if (code_strobe) begin
          usd_enough_d  = 1'b0;
          usd_invalid_d = 1'b0;
          usd_refund_d  = 12'd0;
          if (code_ok && stock_avail) begin
            code_valid_d   = 1'b1;
            code_invalid_d = 1'b0;
            sold_out_d     = 1'b0;
            product_d      = price_of(code_slot);
            slot_d         = code_slot;
            state_d        = ST_PRICE;
          end else begin
            code_valid_d   = 1'b0;
            code_invalid_d = 1'b1;
            sold_out_d     = code_ok;
            product_d      = 12'd0;
            state_d        = ST_RESULT;
          end
        end
      end
      ST_PRICE: begin
        if (cancel) begin
          clear_all = 1'b1;
          state_d   = ST_IDLE;
        end else if (usd_strobe) begin
          if (usd_ok) begin
            usd_enough_d    = 1'b1;
            usd_refund_d    = usd - product_q;
            dec             = 1'b1;
            dispense_d      = 1'b1;
            dispense_slot_d = slot_q;
            cnt_d           = CNT_LOAD;
            state_d         = ST_DISPENSE;
          end else begin
            usd_invalid_d = 1'b1;
            usd_refund_d  = usd;
            state_d       = ST_RESULT;
          end
        end
      end
      ST_DISPENSE: begin
        if (cnt_q == 8'd0) begin
          dispense_d = 1'b0;
          state_d    = ST_RESULT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (clear_all) begin
      code_valid_d   = 1'b0;
      code_invalid_d = 1'b0;
      sold_out_d     = 1'b0;
      product_d      = 12'd0;
      usd_enough_d   = 1'b0;
      usd_invalid_d  = 1'b0;
      usd_refund_d   = 12'd0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      slot_q          <= 4'd0;
      cnt_q           <= 8'd0;
      code_valid_q    <= 1'b0;
      code_invalid_q  <= 1'b0;
      sold_out_q      <= 1'b0;
      product_q       <= 12'd0;
      usd_enough_q    <= 1'b0;
      usd_invalid_q   <= 1'b0;
      usd_refund_q    <= 12'd0;
      dispense_q      <= 1'b0;
      dispense_slot_q <= 4'd0;
    end else begin
      state_q         <= state_d;
      slot_q          <= slot_d;
      cnt_q           <= cnt_d;
      code_valid_q    <= code_valid_d;
      code_invalid_q  <= code_invalid_d;
      sold_out_q      <= sold_out_d;
      product_q       <= product_d;
      usd_enough_q    <= usd_enough_d;
      usd_invalid_q   <= usd_invalid_d;
      usd_refund_q    <= usd_refund_d;
      dispense_q      <= dispense_d;
      dispense_slot_q <= dispense_slot_d;
    end
  end

  assign code_valid    = code_valid_q;
  assign code_invalid  = code_invalid_q;
  assign sold_out      = sold_out_q;
  assign product       = product_q;
  assign usd_enough    = usd_enough_q;
  assign usd_invalid   = usd_invalid_q;
  assign usd_refund    = usd_refund_q;
  assign dispense      = dispense_q;
  assign dispense_slot = dispense_slot_q;
  assign busy          = (state_q == ST_PRICE) || (state_q == ST_DISPENSE);

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Self-checking bench: directed scenarios plus random transactions compared
// against a transaction-level model of the vending rules.
module tb_vend_dispense_ctrl;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset, code_strobe, usd_strobe, cancel, restock;
  logic [7:0]  code;
  logic [11:0] usd;
  logic        code_valid, code_invalid, sold_out, usd_enough, usd_invalid;
  logic        dispense, busy;
  logic [11:0] product, usd_refund;
  logic [3:0]  dispense_slot;

  always #5 clk = ~clk;

  vend_dispense_ctrl #(
    .ROWS(4), .COLS(4), .STOCK_INIT(5), .DISPENSE_CYCLES(D)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .code          (code),
    .code_strobe   (code_strobe),
    .usd           (usd),
    .usd_strobe    (usd_strobe),
    .cancel        (cancel),
    .restock       (restock),
    .code_valid    (code_valid),
    .code_invalid  (code_invalid),
    .sold_out      (sold_out),
    .product       (product),
    .usd_enough    (usd_enough),
    .usd_invalid   (usd_invalid),
    .usd_refund    (usd_refund),
    .dispense      (dispense),
    .dispense_slot (dispense_slot),
    .busy          (busy)
  );

  int checks   = 0;
  int failures = 0;

  // Model: stock per slot, whether a selection awaits payment, expected outputs.
  int stock [16];
  bit await_usd;
  int sel_slot, sel_price;
  int e_cv, e_ci, e_so, e_prod, e_ue, e_ui, e_ref, e_disp, e_busy;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    check({tag, "/code_valid"},   32'(code_valid),   e_cv);
    check({tag, "/code_invalid"}, 32'(code_invalid), e_ci);
    check({tag, "/sold_out"},     32'(sold_out),     e_so);
    check({tag, "/product"},      32'(product),      e_prod);
    check({tag, "/usd_enough"},   32'(usd_enough),   e_ue);
    check({tag, "/usd_invalid"},  32'(usd_invalid),  e_ui);
    check({tag, "/usd_refund"},   32'(usd_refund),   e_ref);
    check({tag, "/dispense"},     32'(dispense),     e_disp);
    check({tag, "/busy"},         32'(busy),         e_busy);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) stock[i] = 5;
    await_usd = 0;
    {e_cv, e_ci, e_so, e_prod, e_ue, e_ui, e_ref, e_disp, e_busy} = '0;
  endtask

  task automatic op_code(input logic [7:0] c, input string tag);
    int row, col, s;
    bit wf;
    code = c;
    code_strobe = 1'b1;
    tick();
    code_strobe = 1'b0;
    if (!await_usd) begin
      row = int'(c[7:4]);
      col = int'(c[3:0]);
      wf  = (row >= 1) && (row <= 4) && (col < 4);
      s   = (row - 1) * 4 + col;
      e_ue = 0; e_ui = 0; e_ref = 0;
      if (wf && stock[s] > 0) begin
        e_cv = 1; e_ci = 0; e_so = 0;
        sel_slot  = s;
        sel_price = 50 + 25 * s;
        e_prod    = sel_price;
        await_usd = 1;
        e_busy    = 1;
      end else begin
        e_cv = 0; e_ci = 1; e_so = int'(wf); e_prod = 0; e_busy = 0;
      end
    end
    check_all(tag);
  endtask

  task automatic op_usd(input int amt, input string tag);
    usd = 12'(amt);
    usd_strobe = 1'b1;
    tick();
    usd_strobe = 1'b0;
    if (await_usd) begin
      await_usd = 0;
      if (amt <= 999 && amt >= sel_price) begin
        e_ue = 1; e_ref = amt - sel_price; stock[sel_slot]--;
        e_disp = 1; e_busy = 1;
        for (int k = 1; k <= D; k++) begin
          if (k > 1) tick();
          check_all($sformatf("%s/disp%0d", tag, k));
          check({tag, "/dispense_slot"}, 32'(dispense_slot), sel_slot);
        end
        tick();
        e_disp = 0; e_busy = 0;
        check_all({tag, "/done"});
        return;
      end
      e_ui = 1; e_ref = amt; e_busy = 0;
    end
    check_all(tag);
  endtask

  task automatic op_cancel(input bit with_usd, input int amt, input string tag);
    cancel = 1'b1;
    usd_strobe = with_usd;
    usd = 12'(amt);
    tick();
    cancel = 1'b0;
    usd_strobe = 1'b0;
    await_usd = 0;
    {e_cv, e_ci, e_so, e_prod, e_ue, e_ui, e_ref, e_disp, e_busy} = '0;
    check_all(tag);
  endtask

  task automatic op_restock(input string tag);
    restock = 1'b1;
    tick();
    restock = 1'b0;
    if (!await_usd) for (int i = 0; i < 16; i++) stock[i] = 5;
    check_all(tag);
  endtask

  initial begin
    int r, amt;
    logic [7:0] c;
    {code_strobe, usd_strobe, cancel, restock} = '0;
    code = '0;
    usd  = '0;
    reset = 1'b1;
    tick();
    tick();
    model_reset();
    check_all("reset");
    reset = 1'b0;

    // Valid purchase with change.
    op_code(8'h12, "tp1_code");
    check("tp1_product_const", 32'(product), 100);
    op_usd(150, "tp1_usd");
    check("tp1_refund_const", 32'(usd_refund), 50);

    // Valid code, insufficient money.
    op_code(8'h30, "tp2_code");
    check("tp2_product_const", 32'(product), 250);
    op_usd(200, "tp2_usd");
    check("tp2_refund_const", 32'(usd_refund), 200);

    // Malformed codes; payment afterwards is ignored.
    op_code(8'h05, "tp3_row0");
    op_code(8'h1A, "tp3_col10");
    op_usd(300, "tp3_usd_ignored");

    // Drain slot 1, hit sold-out, restock.
    for (int i = 0; i < 5; i++) begin
      op_code(8'h11, $sformatf("tp4_code%0d", i));
      op_usd(100, $sformatf("tp4_usd%0d", i));
    end
    op_code(8'h11, "tp4_soldout");
    check("tp4_sold_out_const", 32'(sold_out), 1);
    op_restock("tp4_restock");
    op_code(8'h11, "tp4_after_restock");
    check("tp4_valid_const", 32'(code_valid), 1);
    op_cancel(1'b0, 0, "tp4_cancel");

    // Cancel beats a simultaneous payment.
    op_code(8'h21, "tp5_code");
    op_cancel(1'b1, 500, "tp5_cancel_usd");

    // Reset during the second dispense cycle.
    op_code(8'h22, "tp6_code");
    usd = 12'd200;
    usd_strobe = 1'b1;
    tick();
    usd_strobe = 1'b0;
    check("tp6_disp_c1", 32'(dispense), 1);
    tick();
    check("tp6_disp_c2", 32'(dispense), 1);
    reset = 1'b1;
    tick();
    model_reset();
    check_all("tp6_reset");
    reset = 1'b0;
    op_code(8'h13, "tp6_code2");
    op_usd(1000, "tp6_usd1000");
    check("tp6_refund_const", 32'(usd_refund), 1000);

    // Random transactions.
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 35) begin
        if ($urandom_range(0, 1) == 0) c = ($urandom_range(0, 1) == 0) ? 8'h11 : 8'h12;
        else begin
          c[7:4] = 4'($urandom_range(0, 5));
          c[3:0] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15))
                                                : 4'($urandom_range(0, 3));
        end
        op_code(c, $sformatf("rnd%0d_code", n));
      end else if (r < 70) begin
        case ($urandom_range(0, 4))
          0:       amt = await_usd ? sel_price : 0;
          1:       amt = await_usd ? sel_price - 1 : 0;
          2:       amt = ($urandom_range(0, 1) == 0) ? 999 : 1000;
          default: amt = int'($urandom_range(0, 1100));
        endcase
        op_usd(amt, $sformatf("rnd%0d_usd", n));
      end else if (r < 80) begin
        op_cancel(1'($urandom_range(0, 1)), int'($urandom_range(0, 999)),
                  $sformatf("rnd%0d_cancel", n));
      end else if (r < 88) begin
        op_restock($sformatf("rnd%0d_restock", n));
      end else begin
        tick();
        check_all($sformatf("rnd%0d_idle", n));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vend_dispense_ctrl.md
Name: vend_dispense_ctrl

Overview:
- Transaction engine sitting directly downstream of the keypad/entry stage.
- Consumes the captured product code and the inserted amount as single-cycle strobes.
- Validates the code against a 4x4 slot catalogue and looks up its price.
- Tracks per-slot stock, decides accept/refund and drives a timed dispense pulse; produces the flags and values the 7-segment display stage shows.

Parameters:
- ROWS, 4, number of valid code rows (row digit 1..ROWS)
- COLS, 4, number of valid code columns (col digit 0..COLS-1)
- STOCK_INIT, 5, per-slot stock loaded at reset/restock (max 15)
- DISPENSE_CYCLES, 4, clk cycles dispense stays high (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- code  in  8  {row digit[7:4], col digit[3:0]}, sampled on code_strobe
- code_strobe  in  1  one-cycle pulse: code captured
- usd  in  12  amount in cents (binary), sampled on usd_strobe
- usd_strobe  in  1  one-cycle pulse: amount captured
- cancel  in  1  one-cycle pulse: abort transaction
- restock  in  1  one-cycle pulse: reload all stock
- code_valid  out  1  code accepted
- code_invalid  out  1  code rejected (bad digits or sold out)
- sold_out  out  1  code well-formed but slot stock is 0
- product  out  12  price of selected slot, 0 when not valid
- usd_enough  out  1  purchase accepted
- usd_invalid  out  1  amount rejected
- usd_refund  out  12  change, or full amount on rejection
- dispense  out  1  vend actuator pulse
- dispense_slot  out  4  slot index being vended
- busy  out  1  state != IDLE and != RESULT

Behaviour:
- Reset: all outputs 0, state IDLE, every stock counter = STOCK_INIT.
- Slot = (row-1)*COLS + col.
  - Well-formed iff 1<=row<=ROWS and col<COLS.
  - Price = 50 + 25*slot cents, 12-bit, from package function.
- States: IDLE, PRICE, DISPENSE, RESULT.
- IDLE:
  - code_strobe registers the decision at t+1.
  - Well-formed with stock>0: code_valid=1, product=price, go PRICE.
  - Otherwise: code_invalid=1, sold_out set if well-formed, product=0, go RESULT.
  - usd_strobe is ignored.
- PRICE:
  - usd_strobe registers at t+1.
  - usd<=999 and usd>=price: usd_enough=1, usd_refund=usd-price, stock[slot] decremented, dispense=1, dispense_slot=slot, go DISPENSE.
  - Otherwise: usd_invalid=1, usd_refund=usd (full return), go RESULT.
  - code_strobe is ignored.
- DISPENSE:
  - dispense held exactly DISPENSE_CYCLES cycles via down-counter, then dispense=0 and go RESULT.
  - Strobes and cancel are ignored.
- RESULT:
  - All flags, product and refund hold.
  - code_strobe clears all flags and is processed as in IDLE in the same cycle.
  - cancel goes to IDLE with flags cleared.
- cancel in PRICE: go IDLE with flags cleared, usd_refund=0.
- cancel has priority over any strobe in the same cycle.
- restock acts only in IDLE or RESULT; otherwise ignored. It takes precedence over a decrement in the same cycle.
- Stock never decrements below 0; the sold-out path guarantees this.
- Flag exclusivity: code_valid and code_invalid are never both 1. usd_enough and usd_invalid are never both 1.
- Reset mid-DISPENSE: dispense=0 on the next edge; stock is reloaded.

Decomposition:
- Package vend_pkg:
  - state enum
  - ROWS/COLS defaults
  - PRICE_BASE=50, PRICE_STEP=25, USD_MAX=999
  - price_of(slot) function
  - slot_of(code) function
- Sub-module vend_stock_bank:
  - 16 x 4-bit counters
  - ports: clk, reset, restock, dec, dec_slot, rd_slot, rd_count

Test Plan:
- Reset, code 0x12 strobe, then usd 150 strobe:
  - code_valid=1, product=100.
  - Then usd_enough=1, usd_refund=50, dispense high 4 cycles with dispense_slot=2.
  - stock[2] goes 5->4; ends in RESULT.
- Code 0x30, usd 200 -> code_valid, product=250; then usd_invalid=1, usd_refund=200, dispense never asserted, stock[8] stays 5.
- Bad code digits:
  - Code 0x05 -> code_invalid=1, sold_out=0, product=0.
  - Code 0x1A -> code_invalid=1.
  - A usd_strobe afterwards changes nothing.
- Sold out and restock:
  - Five successful purchases of 0x11 (price 75, usd 100) -> sixth code 0x11 gives code_invalid=1, sold_out=1.
  - restock, then 0x11 -> code_valid=1.
- Cancel and strobe priority:
  - Code 0x21 valid; cancel and usd_strobe (usd 500) in the same cycle -> IDLE, all flags 0, no dispense, stock unchanged.
- Reset at the 2nd dispense cycle -> dispense=0 next edge, all outputs 0, all stock=5; usd 1000 in PRICE -> usd_invalid, refund 1000.
